// File: rtl/hub75_fetchshift_if.sv
// hub75_fetchshift_if: start/status handshake, frame-buffer read port and panel pins
// of the column fetch/shift engine.
interface hub75_fetchshift_if #(parameter int COL_W = 6);
    logic               start;
    logic [2:0]         bit_in;
    logic [5:0]         row_in;
    logic               busy;
    logic [5+COL_W:0]   ram_addr;
    logic               ram_rd;
    logic [47:0]        ram_data;
    logic               r0, g0, b0, r1, g1, b1;
    logic               shift_clk;
    modport master (
        output start, bit_in, row_in, ram_data,
        input  busy, ram_addr, ram_rd, r0, g0, b0, r1, g1, b1, shift_clk
    );
    modport slave (
        input  start, bit_in, row_in, ram_data,
        output busy, ram_addr, ram_rd, r0, g0, b0, r1, g1, b1, shift_clk
    );
endinterface

// File: rtl/hub75_fetchshift.sv
// hub75_fetchshift: reads one row pair from the frame buffer and shifts one bit plane
// of it into the panel column drivers, four cycles per column.
module hub75_fetchshift #(
    parameter int COLS  = 64,
    parameter int COL_W = 6
) (
    input  logic             sys_clk,
    input  logic             rst,
    hub75_fetchshift_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] SETUP = 3'd3;
    localparam logic [2:0] CLK   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    logic [2:0]       state, state_nx;
    logic [COL_W-1:0] col;
    logic [5:0]       row_lat;
    logic [2:0]       bit_lat;
    logic             last;
    assign last         = col == COL_W'(COLS - 1);
    assign bus.busy     = state != IDLE;
    assign bus.ram_rd   = state == ADDR;
    assign bus.ram_addr = {row_lat, col};
    always_comb begin
        state_nx = (state == IDLE)  ? (bus.start ? ADDR : IDLE) :
                   (state == ADDR)  ? LOAD :
                   (state == LOAD)  ? SETUP :
                   (state == SETUP) ? CLK :
                   (state == CLK)   ? (last ? DONE : ADDR) : IDLE;
    end
    // shift_clk is registered from SETUP so it is high exactly during CLK
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state         <= IDLE;
            col           <= '0;
            row_lat       <= '0;
            bit_lat       <= '0;
            bus.shift_clk <= 1'b0;
            {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1} <= '0;
        end else begin
            state         <= state_nx;
            bus.shift_clk <= state == SETUP;
            if (state == IDLE && bus.start) begin
                row_lat <= bus.row_in;
                bit_lat <= bus.bit_in;
                col     <= '0;
            end
            if (state == CLK && !last)
                col <= col + 1'b1;
            if (state == LOAD)
                {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1} <= {
                    bus.ram_data[{3'd5, bit_lat}], bus.ram_data[{3'd4, bit_lat}],
                    bus.ram_data[{3'd3, bit_lat}], bus.ram_data[{3'd2, bit_lat}],
                    bus.ram_data[{3'd1, bit_lat}], bus.ram_data[{3'd0, bit_lat}]};
        end
    end
endmodule
